inst_mem_responder: RTL and testbench

Instruction-memory responder on the fetch-side memory interface: the initiator drives `MEM_ADDR` and pulses `MEM_CLK`, and this block returns the addressed 32-bit word on `MEM_OUT` by the next `CLK` cycle. It also provides a valid/ready load port so a loader or testbench can program the instruction store while the fetch stage is idle. It sits between the fetch stage and the instruction array, and exposes its FSM state for debug.

---
 rtl/inst_mem_responder.sv | 112 +++++++++++
 tb/tb_inst_mem_responder.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_mem_responder.sv
// inst_mem_responder
// Instruction-memory responder for the fetch-side interface. A 0->1 edge on
// MEM_CLK launches a read whose registered result appears on MEM_OUT one CLK
// later, with a one-cycle RD_DONE pulse. A valid/ready load port programs the
// instruction array whenever no read is being launched in the same cycle.
module inst_mem_responder #(
  parameter int          DEPTH    = 256,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [15:0] MEM_ADDR,
  input  logic        MEM_CLK,
  output logic [31:0] MEM_OUT,
  output logic        RD_DONE,
  output logic        RD_ERR,
  input  logic [15:0] LD_ADDR,
  input  logic [31:0] LD_DATA,
  input  logic        LD_VALID,
  output logic        LD_READY,
  output logic        LD_ERR,
  output logic [15:0] RD_CNT,
  output logic [1:0]  ESTADO
);

  // Index width into the array; the range check below uses all 16 address
  // bits, so the truncated index never aliases an out-of-range address.
  localparam int          AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [16:0] DEPTH_L = 17'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RESP = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  state_t        r_state;
  logic          r_mem_clk_q;
  logic [31:0]   r_mem_out;
  logic          r_rd_done;
  logic          r_rd_err;
  logic          r_ld_err;
  logic [15:0]   r_rd_cnt;
  logic [31:0]   r_mem [DEPTH];

  logic          w_rd_req;
  logic          w_rd_oor;
  logic          w_ld_oor;
  logic          w_ld_acc;
  logic [AW-1:0] w_rd_idx;
  logic [AW-1:0] w_ld_idx;

  // Read launches on the rising edge of the strobe; a held strobe reads once.
  assign w_rd_req = MEM_CLK & ~r_mem_clk_q;
  assign w_rd_oor = ({1'b0, MEM_ADDR} >= DEPTH_L);
  assign w_ld_oor = ({1'b0, LD_ADDR}  >= DEPTH_L);
  assign w_rd_idx = MEM_ADDR[AW-1:0];
  assign w_ld_idx = LD_ADDR[AW-1:0];

  // Reads win over loads: the loader is stalled for the launch cycle.
  assign LD_READY = RST & ~w_rd_req;
  assign w_ld_acc = LD_VALID & LD_READY;

  // Read path, response FSM, read counter and load-error flag.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values regardless of statement order within the block.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state     <= ST_IDLE;
      r_mem_clk_q <= 1'b0;
      r_mem_out   <= 32'h0000_0000;
      r_rd_done   <= 1'b0;
      r_rd_err    <= 1'b0;
      r_ld_err    <= 1'b0;
      r_rd_cnt    <= 16'h0000;
    end else begin
      r_mem_clk_q <= MEM_CLK;
      r_rd_done   <= w_rd_req;
      r_rd_err    <= w_rd_req & w_rd_oor;
      r_ld_err    <= w_ld_acc & w_ld_oor;
      if (w_rd_req) begin
        r_mem_out <= w_rd_oor ? NOP_WORD : r_mem[w_rd_idx];
        r_rd_cnt  <= r_rd_cnt + 16'd1;
        r_state   <= ST_RESP;
      end else begin
        case (r_state)
          ST_IDLE: r_state <= ST_IDLE;
          ST_RESP: r_state <= ST_HOLD;
          ST_HOLD: r_state <= ST_HOLD;
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  // Instruction array write port; out-of-range loads are dropped.
  // NOTE: the array has no reset on purpose -- resetting it would turn the
  // RAM into a wide bank of flops; contents simply persist across RST.
  always_ff @(posedge CLK) begin
    if (w_ld_acc && !w_ld_oor) begin
      r_mem[w_ld_idx] <= LD_DATA;
    end
  end

  assign MEM_OUT = r_mem_out;
  assign RD_DONE = r_rd_done;
  assign RD_ERR  = r_rd_err;
  assign LD_ERR  = r_ld_err;
  assign RD_CNT  = r_rd_cnt;
  assign ESTADO  = r_state;

endmodule

// File: tb/tb_inst_mem_responder.sv
// Self-checking bench for inst_mem_responder. Expected read responses are
// pushed to a scoreboard queue when a strobe is driven and popped when the
// DUT raises RD_DONE. Outputs are sampled on the falling clock edge.
module tb_inst_mem_responder;

  localparam int          DEPTH = 256;
  localparam logic [31:0] NOP   = 32'h0000_0000;

  logic        CLK = 1'b0;
  logic        RST;
  logic [15:0] MEM_ADDR;
  logic        MEM_CLK;
  logic [31:0] MEM_OUT;
  logic        RD_DONE;
  logic        RD_ERR;
  logic [15:0] LD_ADDR;
  logic [31:0] LD_DATA;
  logic        LD_VALID;
  logic        LD_READY;
  logic        LD_ERR;
  logic [15:0] RD_CNT;
  logic [1:0]  ESTADO;

  typedef struct {
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mdl [DEPTH];
  logic [15:0] exp_cnt;
  int          n_checks = 0;
  int          n_fail   = 0;

  inst_mem_responder #(.DEPTH(DEPTH), .NOP_WORD(NOP)) dut (
    .CLK(CLK), .RST(RST),
    .MEM_ADDR(MEM_ADDR), .MEM_CLK(MEM_CLK),
    .MEM_OUT(MEM_OUT), .RD_DONE(RD_DONE), .RD_ERR(RD_ERR),
    .LD_ADDR(LD_ADDR), .LD_DATA(LD_DATA), .LD_VALID(LD_VALID),
    .LD_READY(LD_READY), .LD_ERR(LD_ERR),
    .RD_CNT(RD_CNT), .ESTADO(ESTADO)
  );

  always #5 CLK = ~CLK;

  // Queue the expected response for a read of address a.
  task automatic push_read(input logic [15:0] a);
    exp_t e;
    e.err  = ({1'b0, a} >= 17'(DEPTH));
    e.data = e.err ? NOP : mdl[a[7:0]];
    sb.push_back(e);
    exp_cnt = exp_cnt + 16'd1;
  endtask

  // Wait (bounded) for RD_DONE, then pop and compare the response.
  task automatic wait_resp(input string tag);
    exp_t e;
    int   n = 0;
    @(negedge CLK);
    while (RD_DONE !== 1'b1 && n < 4) begin
      @(negedge CLK);
      n++;
    end
    n_checks++;
    if (RD_DONE !== 1'b1) begin
      n_fail++;
      $display("FAIL %s timeout: RD_DONE never rose", tag);
      void'(sb.pop_front());
    end else begin
      e = sb.pop_front();
      n_checks++;
      if (MEM_OUT !== e.data) begin
        n_fail++; $display("FAIL %s data: got %h expected %h", tag, MEM_OUT, e.data);
      end
      n_checks++;
      if (RD_ERR !== e.err) begin
        n_fail++; $display("FAIL %s rd_err: got %b expected %b", tag, RD_ERR, e.err);
      end
      n_checks++;
      if (ESTADO !== 2'd1) begin
        n_fail++; $display("FAIL %s estado_resp: got %0d expected 1", tag, ESTADO);
      end
      n_checks++;
      if (RD_CNT !== exp_cnt) begin
        n_fail++; $display("FAIL %s rd_cnt: got %h expected %h", tag, RD_CNT, exp_cnt);
      end
    end
  endtask

  // Full read: strobe, response, then verify HOLD keeps the word.
  task automatic do_read(input logic [15:0] a, input string tag);
    logic [31:0] held;
    @(negedge CLK);
    push_read(a);
    held     = sb[sb.size()-1].data;
    MEM_ADDR = a;
    MEM_CLK  = 1'b1;
    wait_resp(tag);
    MEM_CLK = 1'b0;
    @(negedge CLK);
    n_checks++;
    if (ESTADO !== 2'd2 || RD_DONE !== 1'b0 || RD_ERR !== 1'b0) begin
      n_fail++;
      $display("FAIL %s hold: got estado=%0d done=%b err=%b expected 2/0/0", tag, ESTADO, RD_DONE, RD_ERR);
    end
    n_checks++;
    if (MEM_OUT !== held) begin
      n_fail++; $display("FAIL %s hold_data: got %h expected %h", tag, MEM_OUT, held);
    end
  endtask

  // Load one word through the valid/ready port and check LD_ERR.
  task automatic do_load(input logic [15:0] a, input logic [31:0] d, input string tag);
    int n = 0;
    logic oor;
    oor = ({1'b0, a} >= 17'(DEPTH));
    @(negedge CLK);
    LD_ADDR  = a;
    LD_DATA  = d;
    LD_VALID = 1'b1;
    #1;
    while (LD_READY !== 1'b1 && n < 8) begin
      @(negedge CLK); #1; n++;
    end
    n_checks++;
    if (LD_READY !== 1'b1) begin
      n_fail++; $display("FAIL %s ld_ready timeout: got %b expected 1", tag, LD_READY);
    end
    @(posedge CLK);
    if (!oor) mdl[a[7:0]] = d;
    @(negedge CLK);
    LD_VALID = 1'b0;
    n_checks++;
    if (LD_ERR !== oor) begin
      n_fail++; $display("FAIL %s ld_err: got %b expected %b", tag, LD_ERR, oor);
    end
    @(negedge CLK);
    n_checks++;
    if (LD_ERR !== 1'b0) begin
      n_fail++; $display("FAIL %s ld_err_pulse: got %b expected 0", tag, LD_ERR);
    end
  endtask

  task automatic test_reset();
    RST = 1'b0; MEM_ADDR = '0; MEM_CLK = 1'b0;
    LD_ADDR = '0; LD_DATA = '0; LD_VALID = 1'b0;
    exp_cnt = 16'h0000;
    #1;
    n_checks++;
    if (MEM_OUT !== 32'h0 || RD_DONE !== 1'b0 || RD_ERR !== 1'b0 || LD_ERR !== 1'b0 ||
        RD_CNT !== 16'h0 || ESTADO !== 2'd0 || LD_READY !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: got out=%h done=%b err=%b lderr=%b cnt=%h st=%0d rdy=%b expected all 0",
               MEM_OUT, RD_DONE, RD_ERR, LD_ERR, RD_CNT, ESTADO, LD_READY);
    end
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    n_checks++;
    if (ESTADO !== 2'd0 || LD_READY !== 1'b1) begin
      n_fail++; $display("FAIL idle_after_reset: got st=%0d rdy=%b expected 0/1", ESTADO, LD_READY);
    end
  endtask

  task automatic test_load_read();
    do_load(16'd0, 32'h0123_4567, "load0");
    do_load(16'd5, 32'hDEAD_BEEF, "load5");
    do_load(16'd255, 32'hA5A5_5A5A, "load255");
    do_read(16'd5, "read5");
    do_read(16'd0, "read0");
    do_read(16'd255, "read_top");
  endtask

  task automatic test_held_strobe();
    int   pulses = 0;
    exp_t e;
    @(negedge CLK);
    push_read(16'd5);
    MEM_ADDR = 16'd5;
    MEM_CLK  = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      if (i == 3) MEM_CLK = 1'b0;
      if (RD_DONE === 1'b1) begin
        pulses++;
        if (sb.size() > 0) begin
          e = sb.pop_front();
          n_checks++;
          if (MEM_OUT !== e.data) begin
            n_fail++; $display("FAIL held data: got %h expected %h", MEM_OUT, e.data);
          end
        end
      end
    end
    n_checks++;
    if (pulses != 1) begin
      n_fail++; $display("FAIL held pulses: got %0d expected 1", pulses);
    end
    n_checks++;
    if (RD_CNT !== exp_cnt) begin
      n_fail++; $display("FAIL held rd_cnt: got %h expected %h", RD_CNT, exp_cnt);
    end
    sb.delete();
  endtask

  task automatic test_out_of_range();
    do_read(16'h0100, "read_oor");
    do_read(16'hFFFF, "read_ffff");
    do_load(16'h0100, 32'hBAD0_BAD0, "load_oor");
    do_read(16'd0, "readback0");
  endtask

  task automatic test_collision();
    exp_t e;
    do_load(16'd7, 32'h1111_2222, "load7");
    @(negedge CLK);
    push_read(16'd7);
    MEM_ADDR = 16'd7; MEM_CLK = 1'b1;
    LD_ADDR = 16'd7; LD_DATA = 32'h3333_4444; LD_VALID = 1'b1;
    #1;
    n_checks++;
    if (LD_READY !== 1'b0) begin
      n_fail++; $display("FAIL coll ld_ready_launch: got %b expected 0", LD_READY);
    end
    @(negedge CLK);
    e = sb.pop_front();
    n_checks++;
    if (RD_DONE !== 1'b1 || MEM_OUT !== e.data) begin
      n_fail++; $display("FAIL coll old_word: got done=%b data=%h expected 1/%h", RD_DONE, MEM_OUT, e.data);
    end
    #1;
    n_checks++;
    if (LD_READY !== 1'b1) begin
      n_fail++; $display("FAIL coll ld_ready_next: got %b expected 1", LD_READY);
    end
    @(posedge CLK);
    mdl[7] = 32'h3333_4444;
    @(negedge CLK);
    LD_VALID = 1'b0; MEM_CLK = 1'b0;
    do_read(16'd7, "coll_new");
  endtask

  task automatic test_wrap();
    @(negedge CLK);
    force dut.r_rd_cnt = 16'hFFFF;
    #1;
    release dut.r_rd_cnt;
    #1;
    exp_cnt = 16'hFFFF;
    n_checks++;
    if (RD_CNT !== 16'hFFFF) begin
      n_fail++; $display("FAIL wrap preset: got %h expected ffff", RD_CNT);
    end
    do_read(16'd5, "wrap");
  endtask

  task automatic test_reset_mid_read();
    @(negedge CLK);
    push_read(16'd5);
    MEM_ADDR = 16'd5; MEM_CLK = 1'b1;
    wait_resp("pre_reset");
    #2 RST = 1'b0;
    #1;
    n_checks++;
    if (MEM_OUT !== 32'h0 || RD_DONE !== 1'b0 || ESTADO !== 2'd0 || LD_READY !== 1'b0 || RD_CNT !== 16'h0) begin
      n_fail++;
      $display("FAIL async_reset: got out=%h done=%b st=%0d rdy=%b cnt=%h expected 0/0/0/0/0",
               MEM_OUT, RD_DONE, ESTADO, LD_READY, RD_CNT);
    end
    exp_cnt = 16'h0000;
    @(negedge CLK);
    RST = 1'b1;
    push_read(16'd5);
    wait_resp("strobe_high_at_release");
    MEM_CLK = 1'b0;
    @(negedge CLK);
  endtask

  initial begin
    test_reset();
    test_load_read();
    test_held_strobe();
    test_out_of_range();
    test_collision();
    test_wrap();
    test_reset_mid_read();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
